receiver: RTL and testbench



---
 rtl/receiver.sv | 119 +++++++++++
 tb/tb_receiver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// UART receiver: 8N1, LSB first. Two-flop input synchronizer, mid-bit sampling,
// registered one-cycle valid / frame_err strobes.
module receiver #(
  parameter int unsigned CLKS_PER_BIT = 1086,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  assign rx_s      = sync_q[1];
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);

  // Synchronizer resets to idle-high so leaving reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], RxD};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStop: begin
        // Returning to idle at mid-stop-bit leaves half a bit to catch a back-to-back start.
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver, run at a shortened bit period (100 clk/bit) so the
// whole sequence stays short; all expected times scale from that bit period.
module tb_receiver;

  localparam int Cpb  = 100;
  localparam int Half = Cpb / 2;
  // Drive edge to valid-visible: 2 sync cycles + 1 to reach IDLE decision, then schedule.
  localparam int Lat  = 3 + Half + 9 * Cpb;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         vcyc[$];
  logic [7:0] vdat[$];
  int         ferr_n = 0;
  int         ferr_cyc = -1;
  int         both_n = 0;
  int         rise_cyc = -1;
  int         fall_cyc = -1;
  logic       busy_prev = 1'b0;

  receiver #(.CLKS_PER_BIT(Cpb)) dut (
    .clk       (clk),
    .reset     (reset),
    .RxD       (RxD),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcyc.push_back(cyc);
      vdat.push_back(data);
    end
    if (frame_err) begin
      ferr_n++;
      ferr_cyc = cyc;
    end
    if (valid && frame_err) both_n++;
    if (busy && !busy_prev) rise_cyc = cyc;
    if (!busy && busy_prev) fall_cyc = cyc;
    busy_prev = busy;
  end

  // Each call starts and ends 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input int n);
    RxD = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int n);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(b[i], n);
    drive_bit(stop, n);
  endtask

  task automatic clear_log();
    vcyc.delete();
    vdat.delete();
    ferr_n   = 0;
    ferr_cyc = -1;
    rise_cyc = -1;
    fall_cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    // A synchronizer not reset high would fake a start right after release.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy[%0d]: got %b want 0", i, busy); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    int start;
    clear_log();
    start = cyc;
    send_frame(8'hA5, 1'b1, Cpb);
    drive_bit(1'b1, 20);
    checks++; if (vcyc.size() != 1) begin errors++; $display("FAIL nominal_count: got %0d want 1", vcyc.size()); end
    if (vcyc.size() >= 1) begin
      checks++; if (vdat[0] !== 8'hA5) begin errors++; $display("FAIL nominal_data: got %h want a5", vdat[0]); end
      checks++; if (vcyc[0] != start + Lat) begin errors++; $display("FAIL nominal_time: got %0d want %0d", vcyc[0], start + Lat); end
    end
    checks++; if (ferr_n != 0) begin errors++; $display("FAIL nominal_ferr: got %0d want 0", ferr_n); end
    checks++; if (rise_cyc != start + 3) begin errors++; $display("FAIL nominal_busy_rise: got %0d want %0d", rise_cyc, start + 3); end
    checks++; if (fall_cyc != start + Lat) begin errors++; $display("FAIL nominal_busy_fall: got %0d want %0d", fall_cyc, start + Lat); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL nominal_hold: got %h want a5", data); end
  endtask

  task automatic test_glitch();
    int start;
    clear_log();
    start = cyc;
    drive_bit(1'b0, 30);
    drive_bit(1'b1, Cpb);
    checks++; if (vcyc.size() != 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", vcyc.size()); end
    checks++; if (ferr_n != 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_n); end
    checks++; if (fall_cyc != start + 3 + Half) begin errors++; $display("FAIL glitch_busy_fall: got %0d want %0d", fall_cyc, start + 3 + Half); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
  endtask

  task automatic test_framing();
    int start;
    int rise;
    clear_log();
    start = cyc;
    send_frame(8'h3C, 1'b0, Cpb);
    drive_bit(1'b0, 5 * Cpb);
    checks++; if (ferr_n != 1) begin errors++; $display("FAIL frame_err_count: got %0d want 1", ferr_n); end
    checks++; if (ferr_cyc != start + Lat) begin errors++; $display("FAIL frame_err_time: got %0d want %0d", ferr_cyc, start + Lat); end
    checks++; if (vcyc.size() != 0) begin errors++; $display("FAIL frame_valid: got %0d want 0", vcyc.size()); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL frame_data_kept: got %h want a5", data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b want 1", busy); end
    rise = cyc;
    drive_bit(1'b1, 20);
    checks++; if (fall_cyc != rise + 3) begin errors++; $display("FAIL break_exit: got %0d want %0d", fall_cyc, rise + 3); end
    checks++; if (ferr_n != 1) begin errors++; $display("FAIL break_single_err: got %0d want 1", ferr_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int start;
    logic [7:0] exp [3];
    exp[0] = 8'h00;
    exp[1] = 8'hFF;
    exp[2] = 8'h55;
    clear_log();
    start = cyc;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, Cpb);
    drive_bit(1'b1, 20);
    checks++; if (vcyc.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", vcyc.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < vcyc.size()) begin
        checks++; if (vdat[i] !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, vdat[i], exp[i]); end
        checks++; if (vcyc[i] != start + Lat + 10 * Cpb * i) begin
          errors++; $display("FAIL b2b_time[%0d]: got %0d want %0d", i, vcyc[i], start + Lat + 10 * Cpb * i);
        end
      end
    end
    checks++; if (ferr_n != 0) begin errors++; $display("FAIL b2b_ferr: got %0d want 0", ferr_n); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h81;
    clear_log();
    drive_bit(1'b0, Cpb);
    for (int i = 0; i < 4; i++) drive_bit(b[i], Cpb);
    drive_bit(b[4], Half);
    #3 reset = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h want 00", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    RxD = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    drive_bit(1'b1, 20);
    send_frame(8'h7E, 1'b1, Cpb);
    drive_bit(1'b1, 20);
    checks++; if (vcyc.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d want 1", vcyc.size()); end
    if (vcyc.size() >= 1) begin
      checks++; if (vdat[0] !== 8'h7E) begin errors++; $display("FAIL midreset_next: got %h want 7e", vdat[0]); end
    end
    checks++; if (ferr_n != 0) begin errors++; $display("FAIL midreset_ferr: got %0d want 0", ferr_n); end
  endtask

  task automatic test_tolerance();
    int rates [2];
    rates[0] = Cpb * 98 / 100;
    rates[1] = Cpb * 102 / 100;
    for (int r = 0; r < 2; r++) begin
      clear_log();
      send_frame(8'h96, 1'b1, rates[r]);
      drive_bit(1'b1, 20);
      checks++; if (vcyc.size() != 1) begin errors++; $display("FAIL tol_count[%0d]: got %0d want 1", rates[r], vcyc.size()); end
      if (vcyc.size() >= 1) begin
        checks++; if (vdat[0] !== 8'h96) begin errors++; $display("FAIL tol_data[%0d]: got %h want 96", rates[r], vdat[0]); end
      end
      checks++; if (ferr_n != 0) begin errors++; $display("FAIL tol_ferr[%0d]: got %0d want 0", rates[r], ferr_n); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_tolerance();
    checks++; if (both_n != 0) begin errors++; $display("FAIL pulse_overlap: got %0d want 0", both_n); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
